// File: rtl/adma_pkg.sv
// Shared types and AXI encodings for the ADMA datamover.
package adma_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } ar_state_e;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/adma_rr_arb.sv
// Round-robin arbiter: priority rotates to the channel after the last grant.
module adma_rr_arb
    import adma_pkg::*;
#(
    parameter int N   = 4,
    parameter int N_W = idx_w(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic           upd,
    output logic [N-1:0]   gnt_oh,
    output logic [N_W-1:0] gnt_bin
);

    logic [N_W-1:0] ptr;
    logic [N_W:0]   sum;
    logic [N_W-1:0] idx;
    logic           found;

    always_comb begin
        gnt_oh  = '0;
        gnt_bin = '0;
        found   = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr} + (N_W+1)'(i);
            if (sum >= (N_W+1)'(N))
                sum = sum - (N_W+1)'(N);
            idx = sum[N_W-1:0];
            if (!found && req[idx]) begin
                found       = 1'b1;
                gnt_oh[idx] = 1'b1;
                gnt_bin     = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= '0;
        else if (upd)
            ptr <= (gnt_bin == N_W'(N-1)) ? '0 : gnt_bin + 1'b1;
    end

endmodule

// File: rtl/adma_dm_axi_ar_sched.sv
// AR-channel scheduler: arbitrates channel read bursts onto one AXI AR port
// and forwards per-burst info to the R datapath, bounded by outstanding count.
module adma_dm_axi_ar_sched
    import adma_pkg::*;
#(
    parameter int DMA_CHN_NUM   = 4,
    parameter int MST_ID_W      = 5,
    parameter int ATX_ADDR_W    = 32,
    parameter int ATX_LEN_W     = 8,
    parameter int ATX_SIZE_W    = 3,
    parameter int ATX_NUM_OSTD  = DMA_CHN_NUM,
    parameter int DMA_CHN_NUM_W = (DMA_CHN_NUM == 1) ? 1 : $clog2(DMA_CHN_NUM)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ATX_ADDR_W-1:0]    req_addr [0:DMA_CHN_NUM-1],
    input  logic [ATX_LEN_W-1:0]     req_len  [0:DMA_CHN_NUM-1],
    input  logic [ATX_SIZE_W-1:0]    req_size [0:DMA_CHN_NUM-1],
    input  logic [DMA_CHN_NUM-1:0]   req_vld,
    output logic [DMA_CHN_NUM-1:0]   req_rdy,
    input  logic [MST_ID_W-1:0]      atx_id   [0:DMA_CHN_NUM-1],
    output logic [MST_ID_W-1:0]      m_arid_o,
    output logic [ATX_ADDR_W-1:0]    m_araddr_o,
    output logic [ATX_LEN_W-1:0]     m_arlen_o,
    output logic [ATX_SIZE_W-1:0]    m_arsize_o,
    output logic [1:0]               m_arburst_o,
    output logic                     m_arvalid_o,
    input  logic                     m_arready_i,
    output logic [DMA_CHN_NUM_W-1:0] atx_chn_id,
    output logic [MST_ID_W-1:0]      atx_arid,
    output logic [ATX_LEN_W-1:0]     atx_arlen,
    output logic                     atx_vld,
    input  logic                     atx_rdy,
    input  logic                     atx_done
);

    localparam int OSTD_W = $clog2(ATX_NUM_OSTD + 1);

    ar_state_e                state;
    logic [DMA_CHN_NUM-1:0]   win_oh;
    logic [DMA_CHN_NUM-1:0]   gnt_oh;
    logic [DMA_CHN_NUM_W-1:0] gnt_bin;
    logic [OSTD_W-1:0]        ostd_cnt;
    logic                     ar_done;
    logic                     info_done;
    logic                     ar_hs;
    logic                     info_hs;
    logic                     finish;
    logic                     can_grant;
    logic                     cnt_inc;
    logic                     cnt_dec;

    assign ar_hs     = m_arvalid_o & m_arready_i;
    assign info_hs   = atx_vld & atx_rdy;
    assign finish    = (state == ST_ISSUE) & (ar_done | ar_hs)
                     & (info_done | info_hs);
    assign can_grant = (state == ST_IDLE) & (|req_vld)
                     & (ostd_cnt < OSTD_W'(ATX_NUM_OSTD));
    assign req_rdy   = finish ? win_oh : '0;
    assign atx_arid  = m_arid_o;
    assign atx_arlen = m_arlen_o;

    // A done pulse with nothing outstanding is spurious and dropped.
    assign cnt_inc = ar_hs;
    assign cnt_dec = atx_done & (ostd_cnt != '0);

    adma_rr_arb #(
        .N   (DMA_CHN_NUM),
        .N_W (DMA_CHN_NUM_W)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_vld),
        .upd     (can_grant),
        .gnt_oh  (gnt_oh),
        .gnt_bin (gnt_bin)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ostd_cnt <= '0;
        end else if (cnt_inc && !cnt_dec) begin
            ostd_cnt <= ostd_cnt + 1'b1;
        end else if (cnt_dec && !cnt_inc) begin
            ostd_cnt <= ostd_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            win_oh      <= '0;
            atx_chn_id  <= '0;
            m_arid_o    <= '0;
            m_araddr_o  <= '0;
            m_arlen_o   <= '0;
            m_arsize_o  <= '0;
            m_arburst_o <= '0;
            m_arvalid_o <= 1'b0;
            atx_vld     <= 1'b0;
            ar_done     <= 1'b0;
            info_done   <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (can_grant) begin
                        state       <= ST_ISSUE;
                        win_oh      <= gnt_oh;
                        atx_chn_id  <= gnt_bin;
                        m_arid_o    <= atx_id[gnt_bin];
                        m_araddr_o  <= req_addr[gnt_bin];
                        m_arlen_o   <= req_len[gnt_bin];
                        m_arsize_o  <= req_size[gnt_bin];
                        m_arburst_o <= AXI_BURST_INCR;
                        m_arvalid_o <= 1'b1;
                        atx_vld     <= 1'b1;
                        ar_done     <= 1'b0;
                        info_done   <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    if (ar_hs) begin
                        m_arvalid_o <= 1'b0;
                        ar_done     <= 1'b1;
                    end
                    if (info_hs) begin
                        atx_vld   <= 1'b0;
                        info_done <= 1'b1;
                    end
                    if (finish) begin
                        state     <= ST_IDLE;
                        ar_done   <= 1'b0;
                        info_done <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adma_dm_axi_ar_sched.sv
// Self-checking bench for the AR scheduler: vector table plus corner sequences.
module tb_adma_dm_axi_ar_sched;

    localparam int NCH = 4;

    typedef struct {
        int          chn;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [4:0]  id;
    } exp_t;

    typedef struct {
        int          chn;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [4:0]  id;
        exp_t        exp;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [31:0]       req_addr [0:NCH-1];
    logic [7:0]        req_len  [0:NCH-1];
    logic [2:0]        req_size [0:NCH-1];
    logic [NCH-1:0]    req_vld = '0;
    logic [NCH-1:0]    req_rdy;
    logic [4:0]        atx_id   [0:NCH-1];
    logic [4:0]        m_arid_o;
    logic [31:0]       m_araddr_o;
    logic [7:0]        m_arlen_o;
    logic [2:0]        m_arsize_o;
    logic [1:0]        m_arburst_o;
    logic              m_arvalid_o;
    logic              m_arready_i = 1'b1;
    logic [1:0]        atx_chn_id;
    logic [4:0]        atx_arid;
    logic [7:0]        atx_arlen;
    logic              atx_vld;
    logic              atx_rdy = 1'b1;
    logic              atx_done = 1'b0;

    int   total = 0;
    int   bad = 0;
    bit   ar_pending = 0;
    bit   auto_done = 0;
    exp_t ar_q[$];
    exp_t info_q[$];
    vec_t tbl[6];

    adma_dm_axi_ar_sched #(
        .DMA_CHN_NUM  (NCH),
        .MST_ID_W     (5),
        .ATX_ADDR_W   (32),
        .ATX_LEN_W    (8),
        .ATX_SIZE_W   (3),
        .ATX_NUM_OSTD (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_addr    (req_addr),
        .req_len     (req_len),
        .req_size    (req_size),
        .req_vld     (req_vld),
        .req_rdy     (req_rdy),
        .atx_id      (atx_id),
        .m_arid_o    (m_arid_o),
        .m_araddr_o  (m_araddr_o),
        .m_arlen_o   (m_arlen_o),
        .m_arsize_o  (m_arsize_o),
        .m_arburst_o (m_arburst_o),
        .m_arvalid_o (m_arvalid_o),
        .m_arready_i (m_arready_i),
        .atx_chn_id  (atx_chn_id),
        .atx_arid    (atx_arid),
        .atx_arlen   (atx_arlen),
        .atx_vld     (atx_vld),
        .atx_rdy     (atx_rdy),
        .atx_done    (atx_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input int c);
        exp_t e;
        e.chn  = c;
        e.addr = req_addr[c];
        e.len  = req_len[c];
        e.size = req_size[c];
        e.id   = atx_id[c];
        ar_q.push_back(e);
        info_q.push_back(e);
    endtask

    task automatic set_chn(input int c, input logic [31:0] a,
                           input logic [7:0] l, input logic [2:0] s,
                           input logic [4:0] id);
        req_addr[c] = a;
        req_len[c]  = l;
        req_size[c] = s;
        atx_id[c]   = id;
    endtask

    task automatic wait_rdy(input int c, output int lat);
        bit ok = 0;
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_rdy[c]) begin
                ok  = 1;
                lat = k;
                break;
            end
        end
        chk($sformatf("rdy_timeout_ch%0d", c), 64'(ok), 64'd1);
    endtask

    task automatic do_req(input int c);
        int lat;
        push_exp(c);
        req_vld[c] = 1'b1;
        wait_rdy(c, lat);
        @(posedge clk);
        #1 req_vld[c] = 1'b0;
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        req_vld     = '0;
        atx_done    = 1'b0;
        m_arready_i = 1'b1;
        atx_rdy     = 1'b1;
        ar_q.delete();
        info_q.delete();
        ar_pending = 0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Scoreboard: compare every handshake against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (m_arvalid_o && m_arready_i) begin
                    chk("ar_dup", 64'(ar_pending), 64'd0);
                    ar_pending = 1;
                    if (ar_q.size() == 0) begin
                        chk("ar_unexpected", 64'd1, 64'd0);
                    end else begin
                        e = ar_q.pop_front();
                        chk("ar_id", 64'(m_arid_o), 64'(e.id));
                        chk("ar_addr", 64'(m_araddr_o), 64'(e.addr));
                        chk("ar_len", 64'(m_arlen_o), 64'(e.len));
                        chk("ar_size", 64'(m_arsize_o), 64'(e.size));
                        chk("ar_burst", 64'(m_arburst_o), 64'd1);
                    end
                end
                if (atx_vld && atx_rdy) begin
                    if (info_q.size() == 0) begin
                        chk("info_unexpected", 64'd1, 64'd0);
                    end else begin
                        e = info_q.pop_front();
                        chk("info_chn", 64'(atx_chn_id), 64'(e.chn));
                        chk("info_id", 64'(atx_arid), 64'(e.id));
                        chk("info_len", 64'(atx_arlen), 64'(e.len));
                    end
                end
                if (req_rdy != '0) begin
                    chk("rdy_onehot", 64'($onehot(req_rdy)), 64'd1);
                    chk("rdy_after_ar", 64'(ar_pending), 64'd1);
                    ar_pending = 0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (auto_done && !rst && m_arvalid_o && m_arready_i) begin
                @(posedge clk);
                #1 atx_done = 1'b1;
                @(posedge clk);
                #1 atx_done = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int lat, arv, atv;
        int ord[5];
        ord = '{0, 1, 2, 3, 0};
        tbl[0] = '{2, 32'h0000_1000, 8'd7,   3'd2, 5'd5,  '{2, 32'h0000_1000, 8'd7,   3'd2, 5'd5}};
        tbl[1] = '{0, 32'h0000_0000, 8'd0,   3'd0, 5'd0,  '{0, 32'h0000_0000, 8'd0,   3'd0, 5'd0}};
        tbl[2] = '{3, 32'hFFFF_FFFF, 8'd255, 3'd7, 5'd31, '{3, 32'hFFFF_FFFF, 8'd255, 3'd7, 5'd31}};
        tbl[3] = '{1, 32'hDEAD_BEE0, 8'd15,  3'd3, 5'd17, '{1, 32'hDEAD_BEE0, 8'd15,  3'd3, 5'd17}};
        tbl[4] = '{2, 32'h8000_0040, 8'd1,   3'd4, 5'd9,  '{2, 32'h8000_0040, 8'd1,   3'd4, 5'd9}};
        tbl[5] = '{0, 32'h1234_5678, 8'd128, 3'd1, 5'd22, '{0, 32'h1234_5678, 8'd128, 3'd1, 5'd22}};
        for (int i = 0; i < NCH; i++)
            set_chn(i, 32'hA5A5_0000, 8'hEE, 3'd6, 5'd30);

        #2;
        chk("rst_arvalid", 64'(m_arvalid_o), 64'd0);
        chk("rst_atxvld", 64'(atx_vld), 64'd0);
        chk("rst_reqrdy", 64'(req_rdy), 64'd0);
        chk("rst_araddr", 64'(m_araddr_o), 64'd0);
        chk("rst_arid", 64'(m_arid_o), 64'd0);
        chk("rst_arlen", 64'(m_arlen_o), 64'd0);
        chk("rst_arburst", 64'(m_arburst_o), 64'd0);
        chk("rst_chn", 64'(atx_chn_id), 64'd0);
        do_reset();

        // Single-request vectors; done pulses keep the outstanding count low.
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < NCH; i++)
                set_chn(i, ~tbl[v].addr, ~tbl[v].len, ~tbl[v].size, ~tbl[v].id);
            set_chn(tbl[v].chn, tbl[v].addr, tbl[v].len, tbl[v].size, tbl[v].id);
            push_exp(tbl[v].chn);
            void'(ar_q.pop_back());
            void'(info_q.pop_back());
            ar_q.push_back(tbl[v].exp);
            info_q.push_back(tbl[v].exp);
            req_vld[tbl[v].chn] = 1'b1;
            wait_rdy(tbl[v].chn, lat);
            chk($sformatf("vec%0d_lat", v), 64'(lat), 64'd1);
            @(posedge clk);
            #1 req_vld[tbl[v].chn] = 1'b0;
            atx_done = 1'b1;
            @(posedge clk);
            #1 atx_done = 1'b0;
        end

        // All channels requesting: strict rotation from channel 0.
        do_reset();
        auto_done = 1;
        for (int i = 0; i < NCH; i++)
            set_chn(i, 32'h100 * i + 32'h40, 8'(i + 1), 3'd3, 5'(10 + i));
        for (int n = 0; n < 5; n++)
            push_exp(ord[n]);
        req_vld = '1;
        for (int n = 0; n < 5; n++)
            wait_rdy(ord[n], lat);
        @(posedge clk);
        #1 req_vld = '0;
        repeat (4) @(posedge clk);
        auto_done = 0;
        chk("rr_q_drained", 64'(ar_q.size()), 64'd0);

        // Outstanding limit of two holds the third burst until a done.
        do_reset();
        set_chn(0, 32'h2000, 8'd3, 3'd2, 5'd1);
        set_chn(1, 32'h3000, 8'd4, 3'd2, 5'd2);
        set_chn(2, 32'h4000, 8'd5, 3'd2, 5'd3);
        do_req(0);
        do_req(1);
        push_exp(2);
        req_vld[2] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("full_block", 64'(m_arvalid_o), 64'd0);
        end
        @(posedge clk);
        #1 atx_done = 1'b1;
        @(posedge clk);
        #1 atx_done = 1'b0;
        wait_rdy(2, lat);
        chk("ostd_release_lat", 64'(lat), 64'd1);
        @(posedge clk);
        #1 req_vld[2] = 1'b0;

        // AR handshake and done in one cycle leave the count unchanged.
        do_reset();
        set_chn(3, 32'h5000, 8'd6, 3'd1, 5'd4);
        do_req(0);
        push_exp(1);
        req_vld[1] = 1'b1;
        @(posedge clk);
        #1 atx_done = 1'b1;
        wait_rdy(1, lat);
        chk("same_cycle_lat", 64'(lat), 64'd0);
        @(posedge clk);
        #1 atx_done = 1'b0;
        req_vld[1] = 1'b0;
        do_req(2);
        req_vld[3] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("ostd_same_cycle", 64'(m_arvalid_o), 64'd0);
        end
        @(posedge clk);
        #1 req_vld[3] = 1'b0;

        // Slow AR ready: info accepted at once, AR held four cycles.
        do_reset();
        set_chn(1, 32'h6000, 8'd9, 3'd2, 5'd12);
        m_arready_i = 1'b0;
        push_exp(1);
        req_vld[1] = 1'b1;
        arv = 0;
        atv = 0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1 m_arready_i = (k == 4);
            @(negedge clk);
            arv += int'(m_arvalid_o);
            atv += int'(atx_vld);
            chk($sformatf("late_rdy_c%0d", k), 64'(req_rdy[1]), 64'(k == 4));
            chk($sformatf("late_addr_c%0d", k), 64'(m_araddr_o), 64'h6000);
        end
        @(posedge clk);
        #1 req_vld[1] = 1'b0;
        m_arready_i = 1'b1;
        chk("late_arvalid_cycles", 64'(arv), 64'd4);
        chk("late_atxvld_cycles", 64'(atv), 64'd1);

        // Reset during ISSUE drops the burst; channel 0 leads afterwards.
        do_reset();
        do_req(0);
        m_arready_i = 1'b0;
        atx_rdy = 1'b0;
        req_vld[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_arvalid", 64'(m_arvalid_o), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_arvalid", 64'(m_arvalid_o), 64'd0);
        chk("mid_rst_atxvld", 64'(atx_vld), 64'd0);
        chk("mid_rst_reqrdy", 64'(req_rdy), 64'd0);
        chk("mid_rst_araddr", 64'(m_araddr_o), 64'd0);
        chk("mid_rst_arid", 64'(m_arid_o), 64'd0);
        do_reset();
        for (int i = 0; i < NCH; i++)
            set_chn(i, 32'h7000 + 32'h10 * i, 8'd2, 3'd2, 5'(20 + i));
        push_exp(0);
        req_vld = '1;
        wait_rdy(0, lat);
        @(posedge clk);
        #1 req_vld = '0;
        repeat (3) @(posedge clk);

        chk("end_ar_q_empty", 64'(ar_q.size()), 64'd0);
        chk("end_info_q_empty", 64'(info_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adma_dm_axi_ar_sched.md
ADMA_DM_AXI_AR_SCHED -- requirements
Module: adma_dm_axi_ar_sched

Interface
REQ-001 SHALL have parameter DMA_CHN_NUM, default 4, number of DMA channels sharing the AR channel.
REQ-002 SHALL have parameter MST_ID_W, default 5, AXI ID width.
REQ-003 SHALL have parameters ATX_ADDR_W=32, ATX_LEN_W=8, ATX_SIZE_W=3, giving the address, burst length and burst size widths.
REQ-004 SHALL have parameter ATX_NUM_OSTD, default DMA_CHN_NUM, max outstanding read bursts; DMA_CHN_NUM_W derived as in the datapath (1 if DMA_CHN_NUM==1).
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 req_addr/req_len/req_size  in  ATX_ADDR_W/ATX_LEN_W/ATX_SIZE_W per channel [0:DMA_CHN_NUM-1]  burst request from each channel.
REQ-008 req_vld  in  1 per channel  request valid; req_rdy  out  1 per channel  request accepted.
REQ-009 atx_id  in  MST_ID_W per channel  AXI ID owned by each channel.
REQ-010 m_arid_o, m_araddr_o, m_arlen_o, m_arsize_o, m_arburst_o(2), m_arvalid_o  out; m_arready_i  in  AXI AR channel.
REQ-011 atx_chn_id(DMA_CHN_NUM_W), atx_arid(MST_ID_W), atx_arlen(ATX_LEN_W), atx_vld  out; atx_rdy  in  transaction info to the R-channel datapath.
REQ-012 atx_done  in  1  pulse when the R datapath accepts an RLAST beat.

Function
REQ-013 FSM states IDLE, ISSUE; reset state IDLE.
REQ-014 IDLE: if any req_vld and ostd_cnt < ATX_NUM_OSTD, round-robin winner latched into registers and FSM -> ISSUE next cycle; otherwise stay in IDLE.
REQ-015 Round-robin: after granting channel k, highest priority = (k+1) mod DMA_CHN_NUM; after reset channel 0 has the highest priority.
REQ-016 ISSUE: m_arvalid_o and atx_vld both driven high from registered values; latency req_vld -> m_arvalid_o = 1 cycle.
REQ-017 The AR handshake and the info handshake SHALL complete independently; each valid drops the cycle after its own handshake, and its done flag is held.
REQ-018 req_rdy[winner] SHALL pulse high for one cycle in the cycle the later of the two handshakes completes (both in the same cycle allowed); FSM -> IDLE next cycle.
REQ-019 AR payload and atx payload SHALL stay stable while their valid is high and unaccepted.
REQ-020 m_arid_o = atx_arid = atx_id[winner] sampled at grant; m_arlen_o = atx_arlen = req_len; m_arburst_o fixed 2'b01 (INCR).
REQ-021 ostd_cnt width $clog2(ATX_NUM_OSTD+1): +1 on AR handshake, -1 on atx_done, unchanged when both occur in the same cycle.
REQ-022 Full: ostd_cnt == ATX_NUM_OSTD blocks a new grant; a grant already in ISSUE completes.
REQ-023 atx_done while ostd_cnt==0 SHALL be ignored (no underflow).
REQ-024 No channel SHALL receive req_rdy without a completed AR handshake; no ID is issued twice per grant.

Reset
REQ-025 rst SHALL asynchronously force state IDLE, ostd_cnt 0, RR pointer 0, both done flags 0.
REQ-026 During reset: m_arvalid_o, atx_vld, all req_rdy = 0; all payload outputs = 0.
REQ-027 rst asserted mid-ISSUE SHALL drop the pending burst without any req_rdy pulse.

Structure
REQ-028 Shared package adma_pkg SHALL hold the FSM state enum and the AXI burst encoding constants (FIXED/INCR/WRAP).
REQ-029 Round-robin selection SHALL be the sub-module adma_rr_arb (req vector, grant update strobe -> one-hot and binary grant).

Verification
REQ-030 Single request: ch2 req_vld, addr 0x1000, len 7, atx_id[2]=5 -> next cycle m_arvalid_o=1, m_arid_o=5, m_arlen_o=7, m_arburst_o=01, atx_chn_id=2; req_rdy[2] pulses once.
REQ-031 All 4 channels request continuously -> grant order 0,1,2,3,0; no channel is skipped.
REQ-032 ATX_NUM_OSTD=2, no atx_done -> 2 bursts issued, third held in IDLE; one atx_done -> third issues next cycle.
REQ-033 m_arready_i delayed 3 cycles, atx_rdy immediate -> atx_vld 1 cycle, m_arvalid_o 4 cycles, req_rdy after the AR handshake only.
REQ-034 AR handshake and atx_done in the same cycle with ostd_cnt=1 -> ostd_cnt stays 1.
REQ-035 rst pulsed mid-ISSUE -> outputs 0 immediately, no req_rdy; after release ch0 wins first.
